// File: rtl/tmc_uart_phy.sv
// 8N1 UART PHY with 4x-oversampled bit timing; independent TX and RX paths.
// Define TMC_UART_PHY_MAJORITY_EN for 2-of-3 majority voting on each RX sample.
module tmc_uart_phy #(
  parameter int CLOCK_DIVIDE = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       transmit,
  input  logic [7:0] tx_byte,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       is_receiving,
  output logic       is_transmitting,
  output logic       recv_error
);

  localparam int BIT_T = 4 * CLOCK_DIVIDE;
  localparam int CW    = $clog2(BIT_T + 1);
  localparam logic [CW-1:0] T_LAST = CW'(BIT_T - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_ERROR} rx_state_e;

  // TX path
  logic          tx_q, tx_d;
  logic          tx_busy_q, tx_busy_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;

  always_comb begin
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (!tx_busy_q) begin
      if (transmit) begin
        tx_busy_d  = 1'b1;
        tx_d       = 1'b0;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_shift_d = tx_byte;
      end
    end else if (tx_cnt_q == T_LAST) begin
      tx_cnt_d = '0;
      if (tx_bit_q == 4'd9) begin
        tx_busy_d = 1'b0;
        tx_d      = 1'b1;
      end else begin
        // Shifting in ones makes the ninth shift produce the stop bit.
        tx_bit_d   = tx_bit_q + 4'd1;
        tx_d       = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[7:1]};
      end
    end else begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  assign tx              = tx_q;
  assign is_transmitting = tx_busy_q;

  // RX path
  logic          sync1_q, sync2_q;
  logic          rx_smp;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          received_q, received_d;
  logic          recv_error_q, recv_error_d;

`ifdef TMC_UART_PHY_MAJORITY_EN
  // Vote is taken one cycle late so the cycle after the nominal point is available.
  localparam logic [CW-1:0] START_LAST = CW'(2 * CLOCK_DIVIDE);
  logic hist1_q, hist2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
    end
  end
  assign rx_smp = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
`else
  localparam logic [CW-1:0] START_LAST = CW'(2 * CLOCK_DIVIDE - 1);
  assign rx_smp = sync2_q;
`endif

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_byte_d    = rx_byte_q;
    received_d   = 1'b0;
    recv_error_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == START_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_smp ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == T_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_smp, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == T_LAST) begin
          rx_cnt_d = '0;
          if (rx_smp) begin
            received_d = 1'b1;
            rx_byte_d  = rx_shift_q;
            rx_state_d = RX_IDLE;
          end else begin
            recv_error_d = 1'b1;
            rx_state_d   = RX_ERROR;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_ERROR: begin
        // Counts consecutive idle-high cycles; any low restarts the count.
        if (!sync2_q)                rx_cnt_d   = '0;
        else if (rx_cnt_q == T_LAST) rx_state_d = RX_IDLE;
        else                         rx_cnt_d   = rx_cnt_q + 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_byte_q    <= '0;
      received_q   <= 1'b0;
      recv_error_q <= 1'b0;
    end else begin
      sync1_q      <= rx;
      sync2_q      <= sync1_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_byte_q    <= rx_byte_d;
      received_q   <= received_d;
      recv_error_q <= recv_error_d;
    end
  end

  assign received     = received_q;
  assign recv_error   = recv_error_q;
  assign rx_byte      = rx_byte_q;
  assign is_receiving = (rx_state_q != RX_IDLE);

endmodule
